image_load_avalon_master: RTL and testbench

// - Avalon-MM read master that reads back images written by the image store stage and replays them as an Avalon-ST video stream.
// - Images are contiguous in memory from a base byte address, each image exactly sig_words bus words long.
// - Sits between SDRAM/DDR and the downstream video pipeline, e.g. a display or processing chain.

---
 rtl/image_load_avalon_master.sv | 219 +++++++++++++++++++++
 tb/tb_image_load_avalon_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_load_avalon_master.sv
// image_load_avalon_master
// Avalon-MM read master that replays stored images as an Avalon-ST stream.
// Reads are issued against a credit count so the internal show-ahead FIFO
// can never overflow; SOP/EOP are derived from the output word position.
// Optional feature macro: IMAGE_LOAD_CONTINUOUS_EN (endless single-image
// replay when started with sig_image_cnt==0, stopped by a second sig_en).
module image_load_avalon_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH_LOG = 6,
   parameter int STORE_WIDTH    = 4,
   parameter int WORDS_WIDTH    = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [31:0]            avm_address,
   output logic                   avm_read,
   input  logic [DATA_WIDTH-1:0]  avm_readdata,
   input  logic                   avm_waitrequest,
   input  logic                   avm_readdatavalid,
   output logic [DATA_WIDTH-1:0]  dout_data,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   dout_startofpacket,
   output logic                   dout_endofpacket,
   input  logic                   sig_en,
   input  logic [31:0]            sig_address,
   input  logic [STORE_WIDTH-1:0] sig_image_cnt,
   input  logic [WORDS_WIDTH-1:0] sig_words,
   output logic                   sig_busy
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** FIFO_DEPTH_LOG;
   localparam int RES_W = FIFO_DEPTH_LOG + 1;
   localparam logic [RES_W-1:0] FULL_CNT = {1'b1, {FIFO_DEPTH_LOG{1'b0}}};

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef IMAGE_LOAD_CONTINUOUS_EN
   localparam logic CONT_EN = 1'b1;
`else
   localparam logic CONT_EN = 1'b0;
`endif

   logic [1:0]             state;
   logic [31:0]            cfg_addr;
   logic [WORDS_WIDTH-1:0] cfg_words;
   logic                   cfg_cont;
   logic                   stop_req;

   logic [31:0]            req_addr, req_addr_nxt;
   logic [WORDS_WIDTH-1:0] req_words, req_words_nxt;
   logic [STORE_WIDTH-1:0] req_images, req_images_nxt;
   logic [RES_W-1:0]       reserved, reserved_nxt;
   logic                   avm_read_nxt;

   logic [DATA_WIDTH-1:0]     mem [DEPTH];
   logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
   logic [RES_W-1:0]          count;

   logic [WORDS_WIDTH-1:0] out_words;
   logic [STORE_WIDTH-1:0] out_images;

   logic start, accept, pop, fifo_full, fifo_wr, eop_word, last_pop, run_nxt;

   // Handshake decodes and the end-of-run condition
   always_comb begin
      // A read left stalled from a stopped continuous run must drain before
      // the address register may be reloaded by a new start.
      start     = (state == S_IDLE) && sig_en && !avm_read &&
                  (sig_words != '0) && ((sig_image_cnt != '0) || CONT_EN);
      accept    = avm_read && !avm_waitrequest;
      pop       = dout_valid && dout_ready;
      fifo_full = (count == FULL_CNT);
      eop_word  = (out_words == cfg_words - WORDS_WIDTH'(1));
      last_pop  = (state == S_RUN) && pop && eop_word &&
                  (cfg_cont ? stop_req : (out_images == STORE_WIDTH'(1)));
      fifo_wr   = (state == S_RUN) && !last_pop && avm_readdatavalid && !fifo_full;
      run_nxt   = start || ((state == S_RUN) && !last_pop);
   end

   // Next request address/counters, credit count and read strobe
   always_comb begin
      req_addr_nxt   = req_addr;
      req_words_nxt  = req_words;
      req_images_nxt = req_images;
      reserved_nxt   = reserved;
      if (start) begin
         req_addr_nxt   = sig_address;
         req_words_nxt  = sig_words;
         req_images_nxt = (sig_image_cnt == '0) ? STORE_WIDTH'(1) : sig_image_cnt;
         reserved_nxt   = '0;
      end else if (state == S_RUN) begin
         reserved_nxt = reserved + RES_W'(accept) - RES_W'(pop);
         if (accept) begin
            if (req_words == WORDS_WIDTH'(1)) begin
               req_words_nxt = cfg_words;
               // Continuous replay keeps one image pending and rewinds the
               // address; a pending stop lets this image be the last one.
               if (cfg_cont && !stop_req) begin
                  req_addr_nxt = cfg_addr;
               end else begin
                  req_addr_nxt   = req_addr + 32'(BYTES);
                  req_images_nxt = req_images - STORE_WIDTH'(1);
               end
            end else begin
               req_words_nxt = req_words - WORDS_WIDTH'(1);
               req_addr_nxt  = req_addr + 32'(BYTES);
            end
         end
      end
      if (avm_read && avm_waitrequest)
         avm_read_nxt = 1'b1;
      else
         avm_read_nxt = run_nxt && (req_images_nxt != '0) && (reserved_nxt < FULL_CNT);
   end

   // Request-side registers
   always_ff @(posedge clk) begin
      if (rst) begin
         avm_read   <= 1'b0;
         req_addr   <= '0;
         req_words  <= '0;
         req_images <= '0;
         reserved   <= '0;
      end else begin
         avm_read   <= avm_read_nxt;
         req_addr   <= req_addr_nxt;
         req_words  <= req_words_nxt;
         req_images <= req_images_nxt;
         reserved   <= reserved_nxt;
      end
   end

   // Control FSM, configuration latch and output word/image position
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cfg_addr   <= '0;
         cfg_words  <= '0;
         cfg_cont   <= 1'b0;
         stop_req   <= 1'b0;
         out_words  <= '0;
         out_images <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RUN;
                  cfg_addr   <= sig_address;
                  cfg_words  <= sig_words;
                  cfg_cont   <= CONT_EN && (sig_image_cnt == '0);
                  stop_req   <= 1'b0;
                  out_words  <= '0;
                  out_images <= sig_image_cnt;
               end
            end
            S_RUN: begin
               if (cfg_cont && sig_en)
                  stop_req <= 1'b1;
               if (pop) begin
                  if (eop_word) begin
                     out_words <= '0;
                     if (!cfg_cont)
                        out_images <= out_images - STORE_WIDTH'(1);
                  end else begin
                     out_words <= out_words + WORDS_WIDTH'(1);
                  end
               end
               if (last_pop)
                  state <= S_DONE;
            end
            S_DONE: begin
               state    <= S_IDLE;
               stop_req <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers; words read ahead past a continuous-mode stop are flushed
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (last_pop) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (fifo_wr)
            wr_ptr <= wr_ptr + FIFO_DEPTH_LOG'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_DEPTH_LOG'(1);
         count <= count + RES_W'(fifo_wr) - RES_W'(pop);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (fifo_wr)
         mem[wr_ptr] <= avm_readdata;
   end

   assign avm_address        = req_addr;
   assign dout_valid         = (count != '0);
   assign dout_data          = dout_valid ? mem[rd_ptr] : '0;
   assign dout_startofpacket = dout_valid && (out_words == '0);
   assign dout_endofpacket   = dout_valid && eop_word;
   assign sig_busy           = (state != S_IDLE);

   // The credit count must keep returning data from overrunning the FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !((state == S_RUN) && avm_readdatavalid && fifo_full));

endmodule

// File: tb/tb_image_load_avalon_master.sv
// Testbench for image_load_avalon_master: randomized slave stalls and
// stream back-pressure, checked against an index-based image model.
module tb_image_load_avalon_master;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata = '0;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] dout_data;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic        dout_startofpacket;
   logic        dout_endofpacket;
   logic        sig_en = 1'b0;
   logic [31:0] sig_address = '0;
   logic [3:0]  sig_image_cnt = '0;
   logic [23:0] sig_words = '0;
   logic        sig_busy;

   always #5 clk = ~clk;

   image_load_avalon_master #(
      .DATA_WIDTH(32), .FIFO_DEPTH_LOG(6), .STORE_WIDTH(4), .WORDS_WIDTH(24)
   ) dut (
      .clk(clk), .rst(rst),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid),
      .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
      .sig_en(sig_en), .sig_address(sig_address), .sig_image_cnt(sig_image_cnt),
      .sig_words(sig_words), .sig_busy(sig_busy)
   );

   typedef struct {
      logic [31:0] data;
      int unsigned due;
   } rsp_t;

   rsp_t        rsp_q[$];
   int unsigned n_checks = 0, n_fail = 0;
   int unsigned cyc = 0, wait_pct = 0, ready_pct = 100;
   int unsigned m_words = 1, m_total = 0, ridx = 0, oidx = 0, acc_total = 0;
   int unsigned last_pop_cyc = 0;
   logic [31:0] m_base = '0, stall_addr = '0;
   logic        m_cont = 1'b0, was_stall = 1'b0, last_eop = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Address of the i-th word of the replayed stream
   function automatic logic [31:0] exp_addr(input int unsigned i);
      if (m_cont) return m_base + 32'((i % m_words) * 4);
      return m_base + 32'(i * 4);
   endfunction

   // One clock: drive inputs at the falling edge, then score what the
   // coming rising edge will accept and pop.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (was_stall) begin
         check("stall_read", avm_read, 1);
         check("stall_addr", avm_address, stall_addr);
      end
      avm_waitrequest = ($urandom_range(99) < wait_pct);
      dout_ready      = ($urandom_range(99) < ready_pct);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = rsp_q[0].data;
         void'(rsp_q.pop_front());
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = '0;
      end
      was_stall  = avm_read && avm_waitrequest && !rst;
      stall_addr = avm_address;
      if (avm_read && !avm_waitrequest) begin
         acc_total++;
         if (!m_cont && ridx >= m_total)
            check("rd_count", ridx + 1, m_total);
         else
            check("rd_addr", avm_address, exp_addr(ridx));
         rsp_q.push_back('{data: mem_word(avm_address), due: cyc + LAT});
         ridx++;
      end
      if (dout_valid && dout_ready) begin
         if (!m_cont && oidx >= m_total) begin
            check("pop_count", oidx + 1, m_total);
         end else begin
            check("dout_data", dout_data, mem_word(exp_addr(oidx)));
            check("dout_sop", dout_startofpacket, (oidx % m_words) == 0);
            check("dout_eop", dout_endofpacket, (oidx % m_words) == m_words - 1);
         end
         last_eop     = dout_endofpacket;
         last_pop_cyc = cyc;
         oidx++;
      end
   endtask

   task automatic start(input logic [31:0] a, input int unsigned cnt, input int unsigned w);
      m_base  = a;
      m_words = w;
      m_cont  = (cnt == 0);
      m_total = cnt * w;
      ridx    = 0;
      oidx    = 0;
      sig_address   = a;
      sig_image_cnt = cnt[3:0];
      sig_words     = w[23:0];
      sig_en        = 1'b1;
      step();
      sig_en = 1'b0;
      check("start_busy", sig_busy, 1);
      check("start_read", avm_read, 1);
   endtask

   task automatic run_until_idle(input int unsigned max);
      int unsigned n = 0;
      while (sig_busy && n < max) begin
         step();
         n++;
      end
      if (sig_busy) begin
         check("busy_timeout", sig_busy, 0);
      end else begin
         check("busy_fall", cyc, last_pop_cyc + 2);
         if (!m_cont) begin
            check("n_reads", ridx, m_total);
            check("n_out", oidx, m_total);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_read"}, avm_read, 0);
      check({tag, "_addr"}, avm_address, 0);
      check({tag, "_valid"}, dout_valid, 0);
      check({tag, "_data"}, dout_data, 0);
      check({tag, "_sop"}, dout_startofpacket, 0);
      check({tag, "_eop"}, dout_endofpacket, 0);
      check({tag, "_busy"}, sig_busy, 0);
   endtask

   initial begin
      int unsigned acc_before;
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Two 4-word images, zero-wait slave, free-running sink
      wait_pct = 0; ready_pct = 100;
      start(32'h1000, 2, 4);
      run_until_idle(200);

      // Sink stalled: credit limit caps accepted reads at the FIFO depth
      ready_pct = 0;
      start(32'h2000, 1, 100);
      repeat (120) step();
      check("credit_reads", ridx, 64);
      check("credit_hold", avm_read, 0);
      check("credit_noout", oidx, 0);
      ready_pct = 100;
      run_until_idle(600);

      // Random slave stalls and sink back-pressure
      wait_pct = 50; ready_pct = 70;
      start(32'h4000, 3, 7);
      run_until_idle(800);

      // A start request while busy is ignored
      wait_pct = 20; ready_pct = 80;
      start(32'h6000, 2, 5);
      repeat (6) step();
      sig_address = 32'h8000; sig_image_cnt = 4'd7; sig_words = 24'd9; sig_en = 1'b1;
      step();
      sig_en = 1'b0;
      run_until_idle(400);

      // Single-word images carry SOP and EOP together
      start(32'h7000, 3, 1);
      run_until_idle(200);

`ifndef IMAGE_LOAD_CONTINUOUS_EN
      // Zero image count never starts a run
      acc_before = acc_total;
      sig_address = 32'h7100; sig_image_cnt = 4'd0; sig_words = 24'd4; sig_en = 1'b1;
      step();
      sig_en = 1'b0;
      repeat (20) step();
      check("cnt0_busy", sig_busy, 0);
      check("cnt0_reads", acc_total, acc_before);
`endif

      // Reset in the middle of an image, then a clean restart
      wait_pct = 0; ready_pct = 100;
      start(32'h9000, 3, 20);
      repeat (25) step();
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst = 1'b0;
      repeat (10) step();
      start(32'hA000, 2, 6);
      run_until_idle(300);

`ifdef IMAGE_LOAD_CONTINUOUS_EN
      // Endless replay of one image, stopped by a second start pulse
      wait_pct = 30; ready_pct = 90;
      start(32'h1000, 0, 4);
      repeat (30) step();
      sig_en = 1'b1;
      step();
      sig_en = 1'b0;
      run_until_idle(400);
      check("stop_eop", last_eop, 1);
      check("stop_whole", oidx % 4, 0);
      check("stop_some", oidx > 4, 1);
`endif

      repeat (5) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
